// File: rtl/cmul_result_checker_pkg.sv
// Shared definitions for the complex-multiplier result checker: FSM encoding,
// I/Q packing constants and parameter defaults.
package cmul_result_checker_pkg;

    localparam int DEF_DATA_WIDTH = 16;
    localparam int DEF_NDATA      = 16384;
    localparam int DEF_ADDR_W     = 14;

    // Samples are packed {I, Q}, I in the upper half
    localparam int IQ_COMPONENTS  = 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SKIP,
        ST_RUN,
        ST_FLUSH,
        ST_DONE
    } chk_state_t;

endpackage

// File: rtl/cmul_result_checker_if.sv
// Sample stream and expected-RAM write port feeding the result checker.
interface cmul_result_checker_if
    import cmul_result_checker_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_W     = DEF_ADDR_W
);

    logic                                  in_valid;
    logic [IQ_COMPONENTS*DATA_WIDTH-1:0]   in_data;
    logic                                  exp_wr_en;
    logic [ADDR_W-1:0]                     exp_wr_addr;
    logic [IQ_COMPONENTS*DATA_WIDTH-1:0]   exp_wr_data;

    modport master (
        output in_valid,
        output in_data,
        output exp_wr_en,
        output exp_wr_addr,
        output exp_wr_data
    );

    modport slave (
        input in_valid,
        input in_data,
        input exp_wr_en,
        input exp_wr_addr,
        input exp_wr_data
    );

endinterface

// File: rtl/cmul_chk_ram.sv
// Simple dual-port synchronous RAM holding the expected vectors: one write
// port and one registered read port.
module cmul_chk_ram #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 14
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/cmul_result_checker.sv
// Sink/checker for cmul output streams: compares each accepted sample with the
// expected RAM within TOL. Optional macro CMUL_CHK_CAPTURE_EN keeps err_sample.
module cmul_result_checker
    import cmul_result_checker_pkg::*;
#(
    parameter int                    DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int                    NDATA      = DEF_NDATA,
    parameter int                    ADDR_W     = DEF_ADDR_W,
    parameter int                    SKIP       = 0,
    parameter logic [DATA_WIDTH-1:0] TOL        = '0
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic                                start,
    cmul_result_checker_if.slave                bus,
    output logic                                busy,
    output logic                                done,
    output logic                                pass,
    output logic [ADDR_W:0]                     err_count,
    output logic [ADDR_W-1:0]                   first_err_idx,
    output logic [ADDR_W:0]                     sample_count,
    output logic [IQ_COMPONENTS*DATA_WIDTH-1:0] err_sample
);

    localparam int                IQ_W      = IQ_COMPONENTS * DATA_WIDTH;
    localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(NDATA - 1);
    localparam logic [ADDR_W:0]   SKIP_LAST = (ADDR_W + 1)'((SKIP > 0) ? SKIP - 1 : 0);
    localparam logic [ADDR_W:0]   ERR_MAX   = '1;

    chk_state_t state_q, state_d;

    logic              arm;
    logic              accept;
    logic              wr_allowed;
    logic [ADDR_W-1:0] idx;
    logic [ADDR_W:0]   skip_cnt;
    logic              flush_cnt;

    logic              s1_valid;
    logic [IQ_W-1:0]   s1_data;
    logic [ADDR_W-1:0] s1_idx;
    logic [IQ_W-1:0]   exp_data;

    logic              s2_valid;
    logic              s2_mismatch;
    logic [ADDR_W-1:0] s2_idx;

    logic signed [DATA_WIDTH:0] diff_i, diff_q;
    logic [DATA_WIDTH:0]        abs_i, abs_q;
    logic                       mismatch;
    logic                       first_hit;

    assign wr_allowed = (state_q == ST_IDLE) || (state_q == ST_DONE);
    assign arm        = start && wr_allowed;
    assign accept     = bus.in_valid && (state_q == ST_RUN);
    assign busy       = (state_q == ST_SKIP) || (state_q == ST_RUN) || (state_q == ST_FLUSH);
    assign done       = (state_q == ST_DONE);
    assign pass       = done && (err_count == '0);
    assign first_hit  = s2_valid && s2_mismatch && (err_count == '0);

    cmul_chk_ram #(
        .DATA_W (IQ_W),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk     (clk),
        .wr_en   (bus.exp_wr_en && wr_allowed),
        .wr_addr (bus.exp_wr_addr),
        .wr_data (bus.exp_wr_data),
        .rd_en   (accept),
        .rd_addr (idx),
        .rd_data (exp_data)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d = (SKIP > 0) ? ST_SKIP : ST_RUN;
                end
            end
            ST_SKIP: begin
                if (bus.in_valid && (skip_cnt == SKIP_LAST)) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (bus.in_valid && (idx == LAST_IDX)) begin
                    state_d = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                if (flush_cnt) begin
                    state_d = ST_DONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            idx       <= '0;
            skip_cnt  <= '0;
            flush_cnt <= 1'b0;
        end else if (arm) begin
            idx       <= '0;
            skip_cnt  <= '0;
            flush_cnt <= 1'b0;
        end else begin
            if ((state_q == ST_SKIP) && bus.in_valid) begin
                skip_cnt <= skip_cnt + 1'b1;
            end
            if (accept) begin
                idx <= idx + 1'b1;
            end
            if (state_q == ST_FLUSH) begin
                flush_cnt <= ~flush_cnt;
            end
        end
    end

    // Stage 1 travels alongside the synchronous RAM read
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1_valid <= 1'b0;
            s1_data  <= '0;
            s1_idx   <= '0;
        end else begin
            s1_valid <= accept;
            if (accept) begin
                s1_data <= bus.in_data;
                s1_idx  <= idx;
            end
        end
    end

    // One extra bit per component so full-scale differences cannot wrap
    always_comb begin
        diff_i   = $signed({s1_data[IQ_W-1], s1_data[IQ_W-1 -: DATA_WIDTH]})
                 - $signed({exp_data[IQ_W-1], exp_data[IQ_W-1 -: DATA_WIDTH]});
        diff_q   = $signed({s1_data[DATA_WIDTH-1], s1_data[DATA_WIDTH-1:0]})
                 - $signed({exp_data[DATA_WIDTH-1], exp_data[DATA_WIDTH-1:0]});
        abs_i    = diff_i[DATA_WIDTH] ? DATA_WIDTH'(0) - diff_i : diff_i;
        abs_q    = diff_q[DATA_WIDTH] ? DATA_WIDTH'(0) - diff_q : diff_q;
        mismatch = (abs_i > {1'b0, TOL}) || (abs_q > {1'b0, TOL});
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s2_valid    <= 1'b0;
            s2_mismatch <= 1'b0;
            s2_idx      <= '0;
        end else begin
            s2_valid    <= s1_valid;
            s2_mismatch <= s1_valid && mismatch;
            s2_idx      <= s1_idx;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            err_count     <= '0;
            first_err_idx <= '0;
            sample_count  <= '0;
        end else if (arm) begin
            err_count     <= '0;
            first_err_idx <= '0;
            sample_count  <= '0;
        end else if (s2_valid) begin
            sample_count <= sample_count + 1'b1;
            if (s2_mismatch && (err_count != ERR_MAX)) begin
                err_count <= err_count + 1'b1;
            end
            if (first_hit) begin
                first_err_idx <= s2_idx;
            end
        end
    end

`ifdef CMUL_CHK_CAPTURE_EN
    logic [IQ_W-1:0] s2_data;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s2_data    <= '0;
            err_sample <= '0;
        end else begin
            s2_data <= s1_data;
            if (arm) begin
                err_sample <= '0;
            end else if (first_hit) begin
                err_sample <= s2_data;
            end
        end
    end
`else
    assign err_sample = '0;
`endif

endmodule

// File: tb/tb_cmul_result_checker.sv
// Directed self-checking bench: five checker instances with different SKIP/TOL
// share one stimulus interface; each test starts only the instances it checks.
module tb_cmul_result_checker;

    localparam int DW = 16;
    localparam int AW = 4;
    localparam int ND = 16;

    localparam int D0  = 0;
    localparam int DT2 = 1;
    localparam int DSK = 2;
    localparam int DFE = 3;
    localparam int DFF = 4;

    logic clk;
    logic reset;
    logic [4:0] start;
    logic [4:0] busy;
    logic [4:0] done;
    logic [4:0] pass;
    logic [AW:0]   err_count     [5];
    logic [AW-1:0] first_err_idx [5];
    logic [AW:0]   sample_count  [5];
    logic [31:0]   err_sample    [5];

    int errors;
    int checks;
    int cyc;

    cmul_result_checker_if #(.DATA_WIDTH(DW), .ADDR_W(AW)) bus ();

    cmul_result_checker #(.DATA_WIDTH(DW), .NDATA(ND), .ADDR_W(AW), .SKIP(0), .TOL(16'h0000)) dut0 (
        .clk(clk), .reset(reset), .start(start[D0]), .bus(bus.slave),
        .busy(busy[D0]), .done(done[D0]), .pass(pass[D0]), .err_count(err_count[D0]),
        .first_err_idx(first_err_idx[D0]), .sample_count(sample_count[D0]), .err_sample(err_sample[D0]));

    cmul_result_checker #(.DATA_WIDTH(DW), .NDATA(ND), .ADDR_W(AW), .SKIP(0), .TOL(16'h0002)) dut_tol2 (
        .clk(clk), .reset(reset), .start(start[DT2]), .bus(bus.slave),
        .busy(busy[DT2]), .done(done[DT2]), .pass(pass[DT2]), .err_count(err_count[DT2]),
        .first_err_idx(first_err_idx[DT2]), .sample_count(sample_count[DT2]), .err_sample(err_sample[DT2]));

    cmul_result_checker #(.DATA_WIDTH(DW), .NDATA(ND), .ADDR_W(AW), .SKIP(3), .TOL(16'h0000)) dut_skip (
        .clk(clk), .reset(reset), .start(start[DSK]), .bus(bus.slave),
        .busy(busy[DSK]), .done(done[DSK]), .pass(pass[DSK]), .err_count(err_count[DSK]),
        .first_err_idx(first_err_idx[DSK]), .sample_count(sample_count[DSK]), .err_sample(err_sample[DSK]));

    cmul_result_checker #(.DATA_WIDTH(DW), .NDATA(ND), .ADDR_W(AW), .SKIP(0), .TOL(16'hFFFE)) dut_fe (
        .clk(clk), .reset(reset), .start(start[DFE]), .bus(bus.slave),
        .busy(busy[DFE]), .done(done[DFE]), .pass(pass[DFE]), .err_count(err_count[DFE]),
        .first_err_idx(first_err_idx[DFE]), .sample_count(sample_count[DFE]), .err_sample(err_sample[DFE]));

    cmul_result_checker #(.DATA_WIDTH(DW), .NDATA(ND), .ADDR_W(AW), .SKIP(0), .TOL(16'hFFFF)) dut_ff (
        .clk(clk), .reset(reset), .start(start[DFF]), .bus(bus.slave),
        .busy(busy[DFF]), .done(done[DFF]), .pass(pass[DFF]), .err_count(err_count[DFF]),
        .first_err_idx(first_err_idx[DFF]), .sample_count(sample_count[DFF]), .err_sample(err_sample[DFF]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic send(input logic [31:0] d);
        @(negedge clk);
        start        = '0;
        bus.in_valid = 1'b1;
        bus.in_data  = d;
    endtask

    task automatic idle_cycle();
        @(negedge clk);
        start        = '0;
        bus.in_valid = 1'b0;
        bus.in_data  = $urandom;
    endtask

    // Fills all 16 entries; the last write shares its cycle with the start pulse
    task automatic load_ram(input bit full_scale, input logic [4:0] start_mask);
        for (int k = 0; k < ND; k++) begin
            @(negedge clk);
            bus.in_valid    = 1'b0;
            bus.exp_wr_en   = 1'b1;
            bus.exp_wr_addr = AW'(k);
            bus.exp_wr_data = full_scale ? 32'h7FFF7FFF : 32'h00010001 * k;
            start           = (k == ND - 1) ? start_mask : 5'b0;
        end
        @(negedge clk);
        bus.exp_wr_en = 1'b0;
        start         = '0;
    endtask

    task automatic wait_done(input int d, output int cycles);
        cycles = 0;
        @(negedge clk);
        bus.in_valid = 1'b0;
        start        = '0;
        while (!done[d] && cycles < 40) begin
            @(negedge clk);
            cycles++;
        end
        checks++;
        if (done[d] !== 1'b1) begin
            errors++;
            $display("[TB] FAIL done_timeout dut%0d: done=%b after %0d cycles, required 1", d, done[d], cycles);
        end
    endtask

    task automatic test_reset();
        checks++;
        if (busy !== 5'b0) begin
            errors++; $display("[TB] FAIL reset_busy: got %b required 00000", busy);
        end
        checks++;
        if (done !== 5'b0) begin
            errors++; $display("[TB] FAIL reset_done: got %b required 00000", done);
        end
        checks++;
        if (pass !== 5'b0) begin
            errors++; $display("[TB] FAIL reset_pass: got %b required 00000", pass);
        end
        checks++;
        if (err_count[D0] !== '0 || first_err_idx[D0] !== '0 || sample_count[D0] !== '0 || err_sample[D0] !== '0) begin
            errors++;
            $display("[TB] FAIL reset_counters: err=%0d idx=%0d cnt=%0d smp=%h required all 0",
                     err_count[D0], first_err_idx[D0], sample_count[D0], err_sample[D0]);
        end
    endtask

    task automatic test_clean_run();
        load_ram(1'b0, 5'b00001 << D0);
        for (int k = 0; k < ND; k++) begin
            if (k == 11) begin
                @(negedge clk);
                bus.in_valid = 1'b0;
                start[D0]    = 1'b1;
            end
            send(32'h00010001 * k);
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
        checks++;
        if (done[D0] !== 1'b0 || busy[D0] !== 1'b1) begin
            errors++; $display("[TB] FAIL clean_flush: done=%b busy=%b required 0/1", done[D0], busy[D0]);
        end
        cyc = 0;
        while (!done[D0] && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
        checks++;
        if (cyc !== 2) begin
            errors++; $display("[TB] FAIL clean_latency: done after %0d cycles, required 2", cyc);
        end
        checks++;
        if (pass[D0] !== 1'b1 || err_count[D0] !== 5'd0) begin
            errors++; $display("[TB] FAIL clean_pass: pass=%b err=%0d required 1/0", pass[D0], err_count[D0]);
        end
        checks++;
        if (sample_count[D0] !== 5'd16) begin
            errors++; $display("[TB] FAIL clean_count: got %0d required 16", sample_count[D0]);
        end
        for (int k = 0; k < 3; k++) send(32'hFFFFFFFF);
        idle_cycle();
        idle_cycle();
        checks++;
        if (sample_count[D0] !== 5'd16 || done[D0] !== 1'b1 || pass[D0] !== 1'b1) begin
            errors++;
            $display("[TB] FAIL done_ignores_valid: cnt=%0d done=%b pass=%b required 16/1/1",
                     sample_count[D0], done[D0], pass[D0]);
        end
    endtask

    task automatic test_mismatch();
        logic [31:0] d;
        load_ram(1'b0, 5'b00001 << D0);
        for (int k = 0; k < ND; k++) begin
            d = 32'h00010001 * k;
            if (k == 5) d = 32'h00060005;
            if (k == 9) d = 32'h00090006;
            send(d);
        end
        send(32'hFFFFFFFF);
        wait_done(D0, cyc);
        checks++;
        if (err_count[D0] !== 5'd2) begin
            errors++; $display("[TB] FAIL mismatch_count: got %0d required 2", err_count[D0]);
        end
        checks++;
        if (first_err_idx[D0] !== 4'd5) begin
            errors++; $display("[TB] FAIL mismatch_first_idx: got %0d required 5", first_err_idx[D0]);
        end
        checks++;
        if (pass[D0] !== 1'b0 || sample_count[D0] !== 5'd16) begin
            errors++; $display("[TB] FAIL mismatch_pass: pass=%b cnt=%0d required 0/16", pass[D0], sample_count[D0]);
        end
`ifdef CMUL_CHK_CAPTURE_EN
        d = 32'h00060005;
`else
        d = 32'h00000000;
`endif
        checks++;
        if (err_sample[D0] !== d) begin
            errors++; $display("[TB] FAIL mismatch_err_sample: got %h required %h", err_sample[D0], d);
        end
    endtask

    task automatic test_tolerance();
        logic [31:0] d;
        load_ram(1'b0, (5'b00001 << D0) | (5'b00001 << DT2));
        for (int k = 0; k < ND; k++) begin
            d = 32'h00010001 * k;
            if (k == 2) d = 32'h00040002;
            if (k == 4) d = 32'h00040002;
            if (k == 7) d = 32'h000A0007;
            send(d);
            if (k == 10) idle_cycle();
        end
        wait_done(DT2, cyc);
        checks++;
        if (err_count[DT2] !== 5'd1 || first_err_idx[DT2] !== 4'd7) begin
            errors++;
            $display("[TB] FAIL tol2_errors: err=%0d idx=%0d required 1/7", err_count[DT2], first_err_idx[DT2]);
        end
        checks++;
        if (pass[DT2] !== 1'b0 || sample_count[DT2] !== 5'd16) begin
            errors++; $display("[TB] FAIL tol2_pass: pass=%b cnt=%0d required 0/16", pass[DT2], sample_count[DT2]);
        end
        checks++;
        if (err_count[D0] !== 5'd3 || first_err_idx[D0] !== 4'd2) begin
            errors++;
            $display("[TB] FAIL tol0_errors: err=%0d idx=%0d required 3/2", err_count[D0], first_err_idx[D0]);
        end
    endtask

    task automatic test_skip();
        load_ram(1'b0, 5'b00001 << DSK);
        send(32'hDEADBEEF);
        send(32'h12345678);
        send(32'hFFFF0000);
        for (int k = 0; k < ND; k++) begin
            idle_cycle();
            send(32'h00010001 * k);
        end
        wait_done(DSK, cyc);
        checks++;
        if (pass[DSK] !== 1'b1 || err_count[DSK] !== 5'd0) begin
            errors++; $display("[TB] FAIL skip_pass: pass=%b err=%0d required 1/0", pass[DSK], err_count[DSK]);
        end
        checks++;
        if (sample_count[DSK] !== 5'd16) begin
            errors++; $display("[TB] FAIL skip_count: got %0d required 16", sample_count[DSK]);
        end
    endtask

    task automatic test_full_scale();
        logic [31:0] d;
        load_ram(1'b1, (5'b00001 << DFE) | (5'b00001 << DFF));
        for (int k = 0; k < ND; k++) send(32'h80008000);
        wait_done(DFE, cyc);
        checks++;
        if (err_count[DFE] !== 5'd16 || first_err_idx[DFE] !== 4'd0 || pass[DFE] !== 1'b0) begin
            errors++;
            $display("[TB] FAIL fullscale_tolfffe: err=%0d idx=%0d pass=%b required 16/0/0",
                     err_count[DFE], first_err_idx[DFE], pass[DFE]);
        end
        checks++;
        if (pass[DFF] !== 1'b1 || err_count[DFF] !== 5'd0 || sample_count[DFF] !== 5'd16) begin
            errors++;
            $display("[TB] FAIL fullscale_tolffff: pass=%b err=%0d cnt=%0d required 1/0/16",
                     pass[DFF], err_count[DFF], sample_count[DFF]);
        end
`ifdef CMUL_CHK_CAPTURE_EN
        d = 32'h80008000;
`else
        d = 32'h00000000;
`endif
        checks++;
        if (err_sample[DFE] !== d) begin
            errors++; $display("[TB] FAIL fullscale_err_sample: got %h required %h", err_sample[DFE], d);
        end
    endtask

    task automatic test_reset_abort();
        load_ram(1'b0, 5'b00001 << D0);
        for (int k = 0; k <= 8; k++) begin
            send(32'h00010001 * k + ((k == 1) ? 32'h00000100 : 32'h0));
            bus.exp_wr_en   = (k == 4);
            bus.exp_wr_addr = 4'd12;
            bus.exp_wr_data = 32'hFFFFFFFF;
        end
        @(negedge clk);
        bus.exp_wr_en = 1'b0;
        bus.in_valid  = 1'b0;
        checks++;
        if (err_count[D0] !== 5'd1 || busy[D0] !== 1'b1) begin
            errors++; $display("[TB] FAIL abort_prerun: err=%0d busy=%b required 1/1", err_count[D0], busy[D0]);
        end
        reset = 1'b0;
        #1;
        checks++;
        if (busy[D0] !== 1'b0 || done[D0] !== 1'b0 || pass[D0] !== 1'b0) begin
            errors++; $display("[TB] FAIL abort_flags: busy=%b done=%b pass=%b required 0/0/0", busy[D0], done[D0], pass[D0]);
        end
        checks++;
        if (err_count[D0] !== '0 || first_err_idx[D0] !== '0 || sample_count[D0] !== '0 || err_sample[D0] !== '0) begin
            errors++;
            $display("[TB] FAIL abort_counters: err=%0d idx=%0d cnt=%0d smp=%h required all 0",
                     err_count[D0], first_err_idx[D0], sample_count[D0], err_sample[D0]);
        end
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        start[D0] = 1'b1;
        for (int k = 0; k < ND; k++) send(32'h00010001 * k);
        wait_done(D0, cyc);
        checks++;
        if (pass[D0] !== 1'b1 || err_count[D0] !== 5'd0 || sample_count[D0] !== 5'd16) begin
            errors++;
            $display("[TB] FAIL restart_pass: pass=%b err=%0d cnt=%0d required 1/0/16",
                     pass[D0], err_count[D0], sample_count[D0]);
        end
    endtask

    initial begin
        errors          = 0;
        checks          = 0;
        reset           = 1'b0;
        start           = '0;
        bus.in_valid    = 1'b0;
        bus.in_data     = '0;
        bus.exp_wr_en   = 1'b0;
        bus.exp_wr_addr = '0;
        bus.exp_wr_data = '0;
        repeat (3) @(negedge clk);
        test_reset();
        reset = 1'b1;
        @(negedge clk);
        test_clean_run();
        test_mismatch();
        test_tolerance();
        test_skip();
        test_full_scale();
        test_reset_abort();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/cmul_result_checker.md
Name: cmul_result_checker

Overview:
- Synthesizable sink and checker for complex-multiplier output streams (packed I/Q, I in upper half).
- Compares each accepted DUT sample against an expected-vector RAM preloaded through a write port.
- Counts mismatches within a per-component tolerance and reports pass/fail, the first failing index and the sample count.
- Sits on the output side of cmul_16 in on-FPGA self-test, mirroring the stimulus source on the input side.

Parameters:
- DATA_WIDTH, 16, width of each I and Q component (signed two's complement).
- NDATA, 16384, number of samples compared per run.
- ADDR_W, 14, expected-RAM address width (2^ADDR_W >= NDATA).
- SKIP, 0, number of leading valid samples discarded before comparison (DUT pipeline priming).
- TOL, 0, maximum allowed absolute per-component error (unsigned, DATA_WIDTH bits).

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse; arms a run from IDLE or DONE.
- in_valid  in  1  DUT sample valid.
- in_data  in  2*DATA_WIDTH  DUT sample, {I,Q}.
- exp_wr_en  in  1  expected-RAM write strobe.
- exp_wr_addr  in  ADDR_W  expected-RAM write address.
- exp_wr_data  in  2*DATA_WIDTH  expected sample, {I,Q}.
- busy  out  1  high in SKIP, RUN and FLUSH.
- done  out  1  high in DONE.
- pass  out  1  done && err_count==0.
- err_count  out  ADDR_W+1  mismatch count, saturating.
- first_err_idx  out  ADDR_W  index of the first mismatch.
- sample_count  out  ADDR_W+1  samples compared so far.
- err_sample  out  2*DATA_WIDTH  first mismatching received sample (optional feature).

Behaviour:
- Reset (reset=0): FSM enters IDLE; all outputs and counters are 0. RAM contents are not cleared.
- Reset asserted mid-run aborts the run immediately; no partial result is retained.
- FSM states: IDLE, SKIP, RUN, FLUSH, DONE.
  - IDLE/DONE + start: clear counters, err_count, first_err_idx and err_sample. Go to SKIP if SKIP>0, else RUN.
  - SKIP: count in_valid; after SKIP valid samples go to RUN. Discarded samples are not compared.
  - RUN: each in_valid issues an expected-RAM read at idx (idx starts at 0) and increments idx. When idx reaches NDATA-1 on a valid cycle, go to FLUSH.
  - FLUSH: 2 cycles to drain the compare pipeline, then DONE.
  - DONE: holds until start or reset.
- start while busy is ignored.
- Compare pipeline, fixed 2-cycle latency from the accepted sample:
  - Stage 1: synchronous RAM read; in_data and idx registered alongside.
  - Stage 2: per component, signed difference in DATA_WIDTH+1 bits; absolute value compared to TOL. Mismatch if either |dI|>TOL or |dQ|>TOL.
- sample_count increments once per stage-2 compare, ending at exactly NDATA.
- err_count increments on each mismatch and saturates at 2^(ADDR_W+1)-1.
- first_err_idx loads on a mismatch only while err_count==0.
- Boundaries:
  - in_valid outside SKIP/RUN is ignored.
  - Gaps in in_valid stall the index without error.
  - Full-scale inputs (0x8000 vs 0x7FFF) produce |d|=65535 without overflow.
  - In_valid arriving in FLUSH is ignored.
- exp_wr_en is honoured only in IDLE/DONE; writes while busy are dropped.
- Same-cycle start and exp_wr_en: the write is performed and the run arms.

Optional Feature:
- CMUL_CHK_CAPTURE_EN defined: err_sample loads in_data of the first mismatch, on the same condition as first_err_idx.
- Undefined: err_sample is tied to 0 and no capture register is built.

Decomposition:
- Shared package holds the FSM state encoding, the IQ pack/unpack width constants and the DATA_WIDTH/ADDR_W defaults.
- One natural sub-module: cmul_chk_ram, a simple dual-port synchronous RAM (write port plus one registered read port).

Test Plan:
- Load RAM with k*0x00010001 (k=0..15), NDATA=16, TOL=0; stream identical data -> done after last sample+2 cycles, pass=1, err_count=0, sample_count=16.
- Same vectors with sample 5 I-part +1 and sample 9 Q-part -3 -> err_count=2, first_err_idx=5, pass=0; err_sample=0x00060005 with CMUL_CHK_CAPTURE_EN.
- TOL=2: errors of +2 and -2 -> pass=1; an error of +3 -> err_count=1.
- SKIP=3: 3 garbage samples, then 16 matching samples with in_valid toggling every other cycle -> pass=1, sample_count=16.
- Expected 0x7FFF7FFF vs received 0x80008000, TOL=0xFFFE -> mismatch; TOL=0xFFFF -> match.
- Reset pulsed low at sample 8 -> all outputs 0, IDLE; exp_wr while busy is dropped; restart with start -> clean pass.
